uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-002 SHALL have parameter CLK_RATE, default 100000000, clock frequency in Hz.
REQ-003 SHALL have parameter WORD_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have parameter EVEN_PARITY, default 0: 1 selects even parity, 0 selects odd parity.
REQ-005 SHALL have port clock, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port tx_data_in, input, WORD_WIDTH, word to transmit.
REQ-008 SHALL have port tx_data_valid, input, 1, tx_data_in is valid.
REQ-009 SHALL have port tx_ready, output, 1, block can accept a word.
REQ-010 SHALL have port tx_out, output, 1, serial line; idle high.
REQ-011 SHALL have port tx_busy, output, 1, frame in progress.

Function
REQ-012 SHALL define BIT_CYCLES = CLK_RATE / BAUD_RATE (integer division); every serial bit SHALL last exactly BIT_CYCLES clocks.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, GUARD.
REQ-014 SHALL accept a word only on a clock where tx_data_valid && tx_ready; tx_ready SHALL be high only in IDLE.
REQ-015 SHALL register tx_data_in on acceptance; later input changes SHALL NOT affect the frame in flight.
REQ-016 SHALL transition IDLE->START on acceptance; tx_out SHALL go low on the clock after acceptance (1-cycle latency).
REQ-017 SHALL send START as one low bit, then DATA as WORD_WIDTH bits LSB first, then PARITY as one bit, then STOP as one high bit, then GUARD as one high bit, then return to IDLE.
REQ-018 SHALL compute the parity bit as ^data when EVEN_PARITY=1 and ~^data when EVEN_PARITY=0, using the registered word.
REQ-019 SHALL keep the GUARD bit because the matching receiver spends one extra bit period in its post-stop wait state; GUARD SHALL NOT be removed.
REQ-020 SHALL make the frame exactly (WORD_WIDTH+4)*BIT_CYCLES clocks from the first low clock to the clock tx_ready reasserts.
REQ-021 SHALL allow back-to-back frames: with valid held high, the next start bit SHALL begin on the clock after the IDLE acceptance cycle; there SHALL be no idle gap beyond GUARD plus the 1 acceptance cycle.
REQ-022 SHALL drive tx_busy = (state != IDLE) and tx_ready = !tx_busy.
REQ-023 SHALL drive tx_out from a register, with no combinational path from inputs to tx_out.
REQ-024 SHALL ignore tx_data_valid outside IDLE and SHALL NOT queue words.
REQ-025 SHALL count data bits with a counter of $clog2(WORD_WIDTH) bits (minimum 1) that wraps only via the reset to 0 on entering DATA.
REQ-026 SHALL use a baud counter that resets to 0 on every state change and at BIT_CYCLES-1.

Reset
REQ-027 SHALL, on rst, force state IDLE, tx_out=1, tx_ready=1 and tx_busy=0, and clear the baud counter, the bit counter and the data register, all on the next clock edge.
REQ-028 SHALL abort a frame when rst asserts mid-frame, driving tx_out high on the next edge with no partial bits afterward.
REQ-029 SHALL NOT accept a word while rst is high.

Structure
REQ-030 SHALL place the state enum (IDLE..GUARD) in shared package uart_pkg, together with the parity function, so that uart_rx can reuse it.
REQ-031 SHALL use one sub-module, uart_baud_gen (parameters CLK_RATE and BAUD_RATE; inputs clear and enable; output tick at BIT_CYCLES-1), shareable with uart_rx.
REQ-032 SHALL contain the FSM, the shift/data register and the parity logic in uart_tx itself.

Verification (CLK_RATE=1000, BAUD_RATE=100, so BIT_CYCLES=10)
REQ-033 SHALL cover: with EVEN_PARITY=0, send 0xA5 -> tx_out low 10 clocks, then 1,0,1,0,0,1,0,1, then parity 1, stop 1, guard 1, each 10 clocks; tx_ready high again 120 clocks after the first low clock.
REQ-034 SHALL cover: with EVEN_PARITY=1, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1.
REQ-035 SHALL cover: hold valid high with 0x55 then 0xFF -> second start bit begins exactly 1 clock after tx_ready rises; 0xFF sends odd parity 1.
REQ-036 SHALL cover: change tx_data_in and pulse valid during DATA -> transmitted bits unchanged and no second frame.
REQ-037 SHALL cover: assert rst for 1 clock at clock 45 of a frame -> tx_out=1 and tx_ready=1 on the next edge, and the line stays high while valid is low.
REQ-038 SHALL cover: loopback of tx_out into uart_rx (same parameters) for 0x00, 0xFF and 0x3C -> rx_data_out matches and rx_bit_error=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, bit-period helper and parity.
package uart_pkg;

  // Widest word the parity helper handles; narrower words are zero-extended.
  localparam int UART_MAX_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GUARD  = 3'd5
  } uart_state_t;

  // Clocks per serial bit (integer division of clock rate by baud rate).
  function automatic int bit_cycles(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

  // Parity bit of a word: even selects XOR-reduction, odd its complement.
  // Zero-extension does not change the reduction, so any width up to the max fits.
  function automatic logic parity_bit(input logic [UART_MAX_WORD_WIDTH-1:0] data,
                                      input logic even_sel);
    logic p_s;
    if (even_sel) begin
      p_s = ^data;
    end else begin
      p_s = ~^data;
    end
    return p_s;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts enabled clocks and ticks on the last clock of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int BIT_CYCLES = bit_cycles(CLK_RATE, BAUD_RATE);
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count clocks within a bit; restart on clear or after the last clock of a bit.
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, parity, stop and one guard bit per frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_RATE    = 100000000,
  parameter int WORD_WIDTH  = 8,
  parameter int EVEN_PARITY = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] tx_data_in,
  input  logic                  tx_data_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy
);

  localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);

  uart_state_t           state_r;
  logic [WORD_WIDTH-1:0] data_r;
  logic [WORD_WIDTH-1:0] shift_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic                  tx_out_r;
  logic                  busy_r;
  logic                  ready_r;
  logic                  tick_s;
  logic                  parity_s;

  // The bit timer runs only while a frame is on the line and is held at zero in IDLE,
  // so each frame starts with a full-length start bit.
  uart_baud_gen #(
    .CLK_RATE  (CLK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_gen (
    .clock  (clock),
    .rst    (rst),
    .clear  (state_r == IDLE),
    .enable (state_r != IDLE),
    .tick   (tick_s)
  );

  assign parity_s = parity_bit(UART_MAX_WORD_WIDTH'(data_r), EVEN_PARITY != 0);

  // Frame sequencer: owns state, captured word, shifter, bit count and all outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r   <= IDLE;
      data_r    <= '0;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      tx_out_r  <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (tx_data_valid) begin
            data_r   <= tx_data_in;
            shift_r  <= tx_data_in;
            state_r  <= START;
            tx_out_r <= 1'b0;
            busy_r   <= 1'b1;
            ready_r  <= 1'b0;
          end else begin
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_r   <= DATA;
            bit_cnt_r <= '0;
            tx_out_r  <= shift_r[0];
            shift_r   <= shift_r >> 1'b1;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              state_r  <= PARITY;
              tx_out_r <= parity_s;
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
              tx_out_r  <= shift_r[0];
              shift_r   <= shift_r >> 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            state_r  <= STOP;
            tx_out_r <= 1'b1;
          end
        end
        STOP: begin
          if (tick_s) begin
            state_r  <= GUARD;
            tx_out_r <= 1'b1;
          end
        end
        GUARD: begin
          // The guard bit covers the receiver's post-stop wait period.
          if (tick_s) begin
            state_r  <= IDLE;
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          tx_out_r <= 1'b1;
          busy_r   <= 1'b0;
          ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_out   = tx_out_r;
  assign tx_busy  = busy_r;
  assign tx_ready = ready_r;

endmodule
